// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute/writeback stage for the 8-bit datapath.
// Captures an operation in IDLE, reads both operands from the register
// file, evaluates a single-cycle ALU op or an 8-step shift-add multiply,
// updates {Z,N,C,V} and writes the result back through gpr_load.
module alu_exec (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic [2:0] rd_idx,
    input  logic [2:0] rs_idx,
    input  logic [7:0] imm,
    input  logic [7:0] rd_val,
    input  logic [7:0] rs_val,
    output logic [2:0] rd_sel,
    output logic [2:0] rs_sel,
    output logic [7:0] data_out,
    output logic       gpr_load,
    output logic       busy,
    output logic       done,
    output logic [3:0] flags
);

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  op_q;
    logic [7:0]  imm_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [2:0]  cnt_q;

    logic [11:0] alu_out;
    logic [15:0] mul_addend;
    logic [15:0] mul_sum;

    // Two's-complement overflow of a+b -> r, judged on the signed views.
    function automatic logic add_ovf(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] r);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic signed [7:0] sr;
        sa = signed'(a);
        sb = signed'(b);
        sr = signed'(r);
        return ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    endfunction

    // Two's-complement overflow of a-b -> r.
    function automatic logic sub_ovf(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] r);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic signed [7:0] sr;
        sa = signed'(a);
        sb = signed'(b);
        sr = signed'(r);
        return ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    endfunction

    // Single-cycle ALU: returns {Z,N,C,V,result}.
    function automatic logic [11:0] alu_eval(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] k);
        logic [8:0] sum;
        logic [7:0] r;
        logic       c;
        logic       v;
        sum = 9'd0;
        r   = 8'h00;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_MOV:  r = b;
            OP_ADD:  begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[7:0]; c = sum[8]; v = add_ovf(a, b, r);
            end
            OP_SUB, OP_CMP: begin
                sum = {1'b0, a} - {1'b0, b};
                r = sum[7:0]; c = sum[8]; v = sub_ovf(a, b, r);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SHL:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SHR:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            OP_LDI:  r = k;
            OP_ADDI: begin
                sum = {1'b0, a} + {1'b0, k};
                r = sum[7:0]; c = sum[8]; v = add_ovf(a, k, r);
            end
            OP_INC:  begin
                sum = {1'b0, a} + 9'd1;
                r = sum[7:0]; c = sum[8]; v = add_ovf(a, 8'h01, r);
            end
            OP_DEC:  begin
                sum = {1'b0, a} - 9'd1;
                r = sum[7:0]; c = sum[8]; v = sub_ovf(a, 8'h01, r);
            end
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), r[7], c, v, r};
    endfunction

    assign alu_out    = alu_eval(op_q, a_q, b_q, imm_q);
    assign mul_addend = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
    assign mul_sum    = acc_q + mul_addend;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        gpr_load  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_READ;
            S_READ: state_nxt = S_EXEC;
            S_EXEC: state_nxt = (op_q == OP_MUL) ? S_MUL : S_WB;
            S_MUL:  if (cnt_q == 3'd7) state_nxt = S_WB;
            S_WB: begin
                done      = 1'b1;
                gpr_load  = (op_q != OP_CMP) && (op_q != OP_NOP);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation capture, operand latch, execute/multiply and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NOP;
            imm_q    <= 8'h00;
            rd_sel   <= 3'd0;
            rs_sel   <= 3'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            acc_q    <= 16'h0000;
            cnt_q    <= 3'd0;
            data_out <= 8'h00;
            flags    <= 4'h0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q   <= opcode;
                    imm_q  <= imm;
                    rd_sel <= rd_idx;
                    rs_sel <= rs_idx;
                end
                S_READ: begin
                    a_q <= rd_val;
                    b_q <= rs_val;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc_q <= 16'h0000;
                        cnt_q <= 3'd0;
                    end else if (op_q != OP_NOP) begin
                        data_out <= alu_out[7:0];
                        flags    <= alu_out[11:8];
                    end
                end
                S_MUL: begin
                    acc_q <= mul_sum;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        data_out <= mul_sum[7:0];
                        flags    <= {(mul_sum[7:0] == 8'h00), mul_sum[7],
                                     (mul_sum[15:8] != 8'h00), 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a small behavioural register file.
module tb_alu_exec;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic [2:0] rd_idx;
    logic [2:0] rs_idx;
    logic [7:0] imm;
    logic [7:0] rd_val;
    logic [7:0] rs_val;
    logic [2:0] rd_sel;
    logic [2:0] rs_sel;
    logic [7:0] data_out;
    logic       gpr_load;
    logic       busy;
    logic       done;
    logic [3:0] flags;

    logic [7:0] rf [8];
    int errors;
    int checks;

    alu_exec dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .rd_idx(rd_idx), .rs_idx(rs_idx), .imm(imm),
        .rd_val(rd_val), .rs_val(rs_val),
        .rd_sel(rd_sel), .rs_sel(rs_sel), .data_out(data_out),
        .gpr_load(gpr_load), .busy(busy), .done(done), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_val = rf[rd_sel];
    assign rs_val = rf[rs_sel];

    // Register file write, taken mid-cycle while the strobe is stable.
    always @(negedge clk) if (gpr_load) rf[rd_sel] = data_out;

    // Issue one op from IDLE and watch it to its done pulse (lat=-1 on timeout).
    task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [7:0] k, output int lat, output int loads,
                          output logic [7:0] wdata, output logic [3:0] fl, output int dones);
        lat = -1; loads = 0; dones = 0; wdata = 8'hxx; fl = 4'hx;
        @(negedge clk);
        opcode = op; rd_idx = rd; rs_idx = rs; imm = k; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            loads += int'(gpr_load);
            if (done) begin
                dones++;
                lat = i; wdata = data_out; fl = flags;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (gpr_load !== 1'b0) begin errors++; $display("FAIL rst_load got %b want 0", gpr_load); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rst_flags got %h want 0", flags); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", data_out); end
        checks++; if ({rd_sel, rs_sel} !== 6'd0) begin errors++; $display("FAIL rst_sel got %0d/%0d want 0/0", rd_sel, rs_sel); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_add();
        int lat, loads, dones; logic [7:0] w; logic [3:0] fl;
        rf[1] = 8'h7F; rf[2] = 8'h01;
        run_op(4'h1, 3'd1, 3'd2, 8'h00, lat, loads, w, fl, dones);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_lat got %0d want 3", lat); end
        checks++; if (loads !== 1) begin errors++; $display("FAIL add_load got %0d want 1", loads); end
        checks++; if (w !== 8'h80) begin errors++; $display("FAIL add_data got %h want 80", w); end
        checks++; if (fl !== 4'b0101) begin errors++; $display("FAIL add_flags got %b want 0101", fl); end
        @(negedge clk);
        checks++; if (rf[1] !== 8'h80) begin errors++; $display("FAIL add_rf got %h want 80", rf[1]); end
    endtask

    task automatic test_sub_cmp();
        int lat, loads, dones; logic [7:0] w; logic [3:0] fl;
        rf[3] = 8'h00; rf[4] = 8'h01; rf[5] = 8'h05; rf[6] = 8'h05;
        run_op(4'h2, 3'd3, 3'd4, 8'h00, lat, loads, w, fl, dones);
        checks++; if (w !== 8'hFF) begin errors++; $display("FAIL sub_data got %h want FF", w); end
        checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL sub_flags got %b want 0110", fl); end
        run_op(4'hC, 3'd5, 3'd6, 8'h00, lat, loads, w, fl, dones);
        checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL cmp_flags got %b want 1000", fl); end
        checks++; if (loads !== 0) begin errors++; $display("FAIL cmp_load got %0d want 0", loads); end
        checks++; if (dones !== 1 || lat !== 3) begin errors++; $display("FAIL cmp_done got %0d@%0d want 1@3", dones, lat); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cmp_after got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (rf[5] !== 8'h05) begin errors++; $display("FAIL cmp_rf got %h want 05", rf[5]); end
    endtask

    task automatic test_mul();
        int lat, loads, dones; logic [7:0] w; logic [3:0] fl;
        rf[1] = 8'h12; rf[2] = 8'h10;
        run_op(4'hB, 3'd1, 3'd2, 8'h00, lat, loads, w, fl, dones);
        checks++; if (lat !== 11) begin errors++; $display("FAIL mul_lat got %0d want 11", lat); end
        checks++; if (loads !== 1) begin errors++; $display("FAIL mul_load got %0d want 1", loads); end
        checks++; if (w !== 8'h20) begin errors++; $display("FAIL mul_data got %h want 20", w); end
        checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL mul_flags got %b want 0010", fl); end
        @(negedge clk);
        checks++; if (rf[1] !== 8'h20) begin errors++; $display("FAIL mul_rf got %h want 20", rf[1]); end
    endtask

    task automatic test_back_to_back();
        int dn [3]; logic [7:0] dv [3]; logic [2:0] ds [3];
        int nd; int idle_busy;
        nd = 0; idle_busy = 0;
        rf[3] = 8'h10;
        @(negedge clk);
        opcode = 4'hD; rd_idx = 3'd3; rs_idx = 3'd6; imm = 8'h00; start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 3) begin dn[nd] = i; dv[nd] = data_out; ds[nd] = rd_sel; end
                nd++;
            end
            if (i == 4 || i == 8) idle_busy += int'(busy);
            if (i == 11) start = 1'b0;
        end
        checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nd); end
        if (nd == 3) begin
            checks++; if (dn[0] !== 3 || dn[1] !== 7 || dn[2] !== 11) begin errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 3,7,11", dn[0], dn[1], dn[2]); end
            checks++; if (dv[0] !== 8'h11 || dv[1] !== 8'h12 || dv[2] !== 8'h13) begin errors++; $display("FAIL b2b_data got %h,%h,%h want 11,12,13", dv[0], dv[1], dv[2]); end
            checks++; if (ds[0] !== 3'd3 || ds[1] !== 3'd3 || ds[2] !== 3'd3) begin errors++; $display("FAIL b2b_rdsel got %0d,%0d,%0d want 3,3,3", ds[0], ds[1], ds[2]); end
        end
        checks++; if (idle_busy !== 0) begin errors++; $display("FAIL b2b_idle got %0d want 0", idle_busy); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || rf[3] !== 8'h13) begin errors++; $display("FAIL b2b_end got busy=%b rf=%h want 0/13", busy, rf[3]); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, loads, dones; logic [7:0] w; logic [3:0] fl;
        rf[3] = 8'hFF; rf[4] = 8'h01;
        run_op(4'h2, 3'd3, 3'd4, 8'h00, lat, loads, w, fl, dones);
        checks++; if (fl !== 4'b0100) begin errors++; $display("FAIL pre_flags got %b want 0100", fl); end
        rf[1] = 8'h20; rf[2] = 8'h10;
        @(negedge clk);
        opcode = 4'hB; rd_idx = 3'd1; rs_idx = 3'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmul_busy got %b want 0", busy); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rmul_flags got %b want 0000", flags); end
        checks++; if (rd_sel !== 3'd0 || data_out !== 8'h00) begin errors++; $display("FAIL rmul_regs got sel=%0d data=%h want 0/00", rd_sel, data_out); end
        loads = 0;
        for (int i = 0; i < 2; i++) begin @(negedge clk); loads += int'(gpr_load); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin @(negedge clk); loads += int'(gpr_load) + int'(done); end
        checks++; if (loads !== 0 || rf[1] !== 8'h20) begin errors++; $display("FAIL rmul_nowrite got %0d strobes rf=%h want 0/20", loads, rf[1]); end
        run_op(4'h9, 3'd4, 3'd0, 8'hA5, lat, loads, w, fl, dones);
        checks++; if (lat !== 3 || loads !== 1 || w !== 8'hA5) begin errors++; $display("FAIL ldi got lat=%0d load=%0d data=%h want 3/1/A5", lat, loads, w); end
        checks++; if (fl !== 4'b0100) begin errors++; $display("FAIL ldi_flags got %b want 0100", fl); end
        @(negedge clk);
        checks++; if (rf[4] !== 8'hA5) begin errors++; $display("FAIL ldi_rf got %h want A5", rf[4]); end
    endtask

    task automatic test_shr_nop();
        int lat, loads, dones; logic [7:0] w; logic [3:0] fl;
        rf[2] = 8'h01; rf[7] = 8'h5A;
        run_op(4'h8, 3'd2, 3'd0, 8'h00, lat, loads, w, fl, dones);
        checks++; if (w !== 8'h00 || loads !== 1) begin errors++; $display("FAIL shr_data got %h load=%0d want 00/1", w, loads); end
        checks++; if (fl !== 4'b1010) begin errors++; $display("FAIL shr_flags got %b want 1010", fl); end
        run_op(4'hF, 3'd7, 3'd7, 8'h00, lat, loads, w, fl, dones);
        checks++; if (fl !== 4'b1010) begin errors++; $display("FAIL nop_flags got %b want 1010", fl); end
        checks++; if (loads !== 0 || dones !== 1 || lat !== 3) begin errors++; $display("FAIL nop_strobes got load=%0d done=%0d@%0d want 0/1@3", loads, dones, lat); end
        @(negedge clk);
        checks++; if (rf[7] !== 8'h5A) begin errors++; $display("FAIL nop_rf got %h want 5A", rf[7]); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; rd_idx = 3'd0; rs_idx = 3'd0; imm = 8'h00;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_shr_nop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
